// File: rtl/pa_fpu.sv
// Shared types and constants for the single-precision FPU.
//   e_fpu_op   : operation select (add, sub, mul, div)
//   c_qnan     : canonical quiet NaN
//   c_pos_inf  : +infinity
//   c_neg_inf  : -infinity
//   c_exp_bias : binary32 exponent bias
//   eff_exp    : exponent used for arithmetic (subnormals live at exponent 1)
package pa_fpu;

   typedef enum logic [1:0] {
      op_add = 2'd0,
      op_sub = 2'd1,
      op_mul = 2'd2,
      op_div = 2'd3
   } e_fpu_op;

   localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
   localparam logic [31:0] c_pos_inf  = 32'h7F80_0000;
   localparam logic [31:0] c_neg_inf  = 32'hFF80_0000;
   localparam int          c_exp_bias = 127;

   function automatic logic [7:0] eff_exp(input logic [7:0] e);
      return (e == 8'd0) ? 8'd1 : e;
   endfunction

endpackage

// File: rtl/fpu_addsub.sv
// Combinational binary32 adder/subtractor with round-to-nearest-even and
// full subnormal support.
//   a, b   : IEEE-754 single operands
//   sub    : 1 computes a - b (b's sign inverted), 0 computes a + b
//   result : IEEE-754 single result
module fpu_addsub
   import pa_fpu::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] result
);

   logic        sa, sb, sl;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        swap;
   logic [7:0]  el, es, d, nsh;
   logic [23:0] ml, ms;
   logic [52:0] shift_buf;
   logic [26:0] ms_al, diff, v;
   logic [27:0] sum;
   logic [9:0]  e;
   logic [4:0]  lz;
   logic        found;
   logic        round_up;
   logic [24:0] m25;
   logic [7:0]  exp_field;

   always_comb begin
      sa        = a[31];
      sb        = b[31] ^ sub;
      ea        = a[30:23];
      eb        = b[30:23];
      fa        = a[22:0];
      fb        = b[22:0];
      a_nan     = (ea == 8'hFF) && (fa != 23'd0);
      b_nan     = (eb == 8'hFF) && (fb != 23'd0);
      a_inf     = (ea == 8'hFF) && (fa == 23'd0);
      b_inf     = (eb == 8'hFF) && (fb == 23'd0);
      a_zero    = (a[30:0] == 31'd0);
      b_zero    = (b[30:0] == 31'd0);

      // Order by magnitude; the raw exponent/fraction bits compare monotonically.
      swap      = (b[30:0] > a[30:0]);
      sl        = swap ? sb : sa;
      el        = swap ? eff_exp(eb) : eff_exp(ea);
      es        = swap ? eff_exp(ea) : eff_exp(eb);
      ml        = swap ? {eb != 8'd0, fb} : {ea != 8'd0, fa};
      ms        = swap ? {ea != 8'd0, fa} : {eb != 8'd0, fb};
      d         = el - es;

      // Align: 24-bit mantissa + guard/round/sticky; lost bits fold into sticky.
      shift_buf = {ms, 29'd0} >> d;
      if (d >= 8'd26)
         ms_al = {26'd0, |ms};
      else
         ms_al = {shift_buf[52:27], shift_buf[26] | (|shift_buf[25:0])};

      sum      = 28'd0;
      diff     = 27'd0;
      v        = 27'd0;
      e        = {2'b00, el};
      lz       = 5'd0;
      found    = 1'b0;
      nsh      = 8'd0;

      if (sa == sb) begin
         sum = {1'b0, ml, 3'b000} + {1'b0, ms_al};
         if (sum[27]) begin
            v = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'd1;
         end else begin
            v = sum[26:0];
         end
      end else begin
         diff = {ml, 3'b000} - ms_al;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (diff[i]) found = 1'b1;
               else         lz    = lz + 5'd1;
            end
         end
         // Never normalise below exponent 1; what remains is a subnormal.
         nsh = ({3'b000, lz} > (el - 8'd1)) ? (el - 8'd1) : {3'b000, lz};
         v   = diff << nsh;
         e   = e - {2'b00, nsh};
      end

      round_up  = v[2] & (v[1] | v[0] | v[3]);
      m25       = {1'b0, v[26:3]} + {24'd0, round_up};
      if (m25[24]) begin
         e = e + 10'd1;
      end
      // Hidden bit absent after rounding means the result is subnormal.
      exp_field = (m25[24] || m25[23]) ? e[7:0] : 8'd0;

      if (a_nan || b_nan)
         result = c_qnan;
      else if (a_inf && b_inf)
         result = (sa != sb) ? c_qnan : {sa, c_pos_inf[30:0]};
      else if (a_inf)
         result = {sa, c_pos_inf[30:0]};
      else if (b_inf)
         result = {sb, c_pos_inf[30:0]};
      else if (a_zero && b_zero)
         result = {sa & sb, 31'd0};
      else if (b_zero)
         result = a;
      else if (a_zero)
         result = {sb, b[30:0]};
      else if ((sa != sb) && (diff == 27'd0))
         result = 32'd0;
      else if (e >= 10'd255)
         result = sl ? c_neg_inf : c_pos_inf;
      else
         result = {sl, exp_field, m25[22:0]};
   end

endmodule

// File: rtl/fpu.sv
// Single-precision FPU top: op decode plus one output register.
//   clk             : clock, rising edge
//   arst_n          : asynchronous active-low reset, clears the output
//   a_operand       : first operand, IEEE-754 single
//   b_operand       : second operand, IEEE-754 single
//   operation       : op_add / op_sub / op_mul / op_div
//   ieee_packet_out : registered result, one cycle after the inputs are sampled
// op_mul and op_div select the canonical qNaN as the result.
module fpu
   import pa_fpu::*;
(
   input  logic        clk,
   input  logic        arst_n,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   input  e_fpu_op     operation,
   output logic [31:0] ieee_packet_out
);

   logic        is_sub;
   logic [31:0] addsub_result;
   logic [31:0] next_result;

   assign is_sub = (operation == op_sub);

   fpu_addsub u_addsub (
      .a      (a_operand),
      .b      (b_operand),
      .sub    (is_sub),
      .result (addsub_result)
   );

   always_comb begin
      next_result = c_qnan;
      if ((operation == op_add) || (operation == op_sub))
         next_result = addsub_result;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         ieee_packet_out <= 32'd0;
      else
         ieee_packet_out <= next_result;
   end

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu.
module tb_fpu;
   import pa_fpu::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      e_fpu_op     op;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        arst_n;
   logic [31:0] a_operand;
   logic [31:0] b_operand;
   e_fpu_op     operation;
   logic [31:0] ieee_packet_out;

   int checks;
   int errors;

   fpu dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .a_operand       (a_operand),
      .b_operand       (b_operand),
      .operation       (operation),
      .ieee_packet_out (ieee_packet_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: apply inputs, let one rising edge capture them, sample 1 after
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op);
      a_operand = a;
      b_operand = b;
      operation = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n    = 1'b0;
      a_operand = 32'h3F80_0000;
      b_operand = 32'h3F80_0000;
      operation = op_add;
      #1;
      checks++;
      if (ieee_packet_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_no_edge got %08h want 00000000", ieee_packet_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_held got %08h want 00000000", ieee_packet_out);
      end
      arst_n = 1'b1;
      #2;
      checks++;
      if (ieee_packet_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_release_no_edge got %08h want 00000000", ieee_packet_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== 32'h4000_0000) begin
         errors++;
         $display("FAIL first_result got %08h want 40000000", ieee_packet_out);
      end
      // output must hold between edges even with new inputs applied
      operation = op_mul;
      #3;
      checks++;
      if (ieee_packet_out !== 32'h4000_0000) begin
         errors++;
         $display("FAIL hold_between_edges got %08h want 40000000", ieee_packet_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== c_qnan) begin
         errors++;
         $display("FAIL mul_after_edge got %08h want 7fc00000", ieee_packet_out);
      end
   endtask

   task automatic test_add();
      vec_t v [8];
      v = '{
         '{32'h3F80_0000, 32'h3F8C_CCCD, op_add, 32'h4006_6666},
         '{32'h4180_0000, 32'h4200_0000, op_add, 32'h4240_0000},
         '{32'h3E80_0000, 32'h3F00_0000, op_add, 32'h3F40_0000},
         '{32'h0000_0001, 32'h0000_0001, op_add, 32'h0000_0002},
         '{32'h007F_FFFF, 32'h0000_0001, op_add, 32'h0080_0000},
         '{32'h3F80_0000, 32'h3380_0000, op_add, 32'h3F80_0000},
         '{32'h3F80_0001, 32'h3380_0000, op_add, 32'h3F80_0002},
         '{32'h3F80_0000, 32'h3380_0001, op_add, 32'h3F80_0001}
      };
      for (int i = 0; i < 8; i++) begin
         drive(v[i].a, v[i].b, v[i].op);
         checks++;
         if (ieee_packet_out !== v[i].exp) begin
            errors++;
            $display("FAIL add[%0d] %08h+%08h got %08h want %08h",
                     i, v[i].a, v[i].b, ieee_packet_out, v[i].exp);
         end
      end
   endtask

   task automatic test_sub();
      vec_t v [5];
      v = '{
         '{32'h3F80_0000, 32'h3F8C_CCCD, op_sub, 32'hBDCC_CCD0},
         '{32'h3FFF_FFFF, 32'h402D_F854, op_sub, 32'hBF37_E152},
         '{32'h4216_8F5C, 32'h0000_0000, op_sub, 32'h4216_8F5C},
         '{32'h3F80_0001, 32'h3F80_0000, op_sub, 32'h3400_0000},
         '{32'h4040_0000, 32'h4040_0000, op_sub, 32'h0000_0000}
      };
      for (int i = 0; i < 5; i++) begin
         drive(v[i].a, v[i].b, v[i].op);
         checks++;
         if (ieee_packet_out !== v[i].exp) begin
            errors++;
            $display("FAIL sub[%0d] %08h-%08h got %08h want %08h",
                     i, v[i].a, v[i].b, ieee_packet_out, v[i].exp);
         end
      end
   endtask

   task automatic test_subnormal();
      vec_t v [8];
      v = '{
         '{32'h0080_0000, 32'h007F_FFFF, op_add, 32'h00FF_FFFF},
         '{32'h0040_0000, 32'h0040_0000, op_add, 32'h0080_0000},
         '{32'h007F_FFFF, 32'h0000_0002, op_add, 32'h0080_0001},
         '{32'h0000_0001, 32'h0000_0001, op_sub, 32'h0000_0000},
         '{32'h8000_0001, 32'h0000_0001, op_sub, 32'h8000_0002},
         '{32'h0070_0000, 32'h000F_FFFF, op_sub, 32'h0060_0001},
         '{32'h0000_0003, 32'h8000_0000, op_add, 32'h0000_0003},
         '{32'h8000_0005, 32'h0000_0000, op_sub, 32'h8000_0005}
      };
      for (int i = 0; i < 8; i++) begin
         drive(v[i].a, v[i].b, v[i].op);
         checks++;
         if (ieee_packet_out !== v[i].exp) begin
            errors++;
            $display("FAIL subnormal[%0d] %08h op%0d %08h got %08h want %08h",
                     i, v[i].a, v[i].op, v[i].b, ieee_packet_out, v[i].exp);
         end
      end
   endtask

   task automatic test_specials();
      vec_t v [12];
      v = '{
         '{32'h7F80_0000, 32'h7F80_0000, op_sub, 32'h7FC0_0000},
         '{32'hFF80_0000, 32'h7F80_0000, op_add, 32'h7FC0_0000},
         '{32'h7FC0_0000, 32'h402D_F854, op_add, 32'h7FC0_0000},
         '{32'h4120_0000, 32'h7F80_0000, op_sub, 32'hFF80_0000},
         '{32'h7F7F_FFFF, 32'h7F7F_FFFF, op_add, 32'h7F80_0000},
         '{32'h0000_0000, 32'h7F80_0000, op_sub, 32'hFF80_0000},
         '{32'h4120_0000, 32'hFF80_0000, op_sub, 32'h7F80_0000},
         '{32'h8000_0000, 32'h8000_0000, op_add, 32'h8000_0000},
         '{32'h0000_0000, 32'h8000_0000, op_add, 32'h0000_0000},
         '{32'h3F80_0000, 32'hFFC0_0001, op_sub, 32'h7FC0_0000},
         '{32'h7F80_0000, 32'hFF80_0000, op_sub, 32'h7F80_0000},
         '{32'hFF7F_FFFF, 32'h7F7F_FFFF, op_sub, 32'hFF80_0000}
      };
      for (int i = 0; i < 12; i++) begin
         drive(v[i].a, v[i].b, v[i].op);
         checks++;
         if (ieee_packet_out !== v[i].exp) begin
            errors++;
            $display("FAIL special[%0d] %08h op%0d %08h got %08h want %08h",
                     i, v[i].a, v[i].op, v[i].b, ieee_packet_out, v[i].exp);
         end
      end
   endtask

   task automatic test_unsupported();
      drive(32'h3F80_0000, 32'h4000_0000, op_mul);
      checks++;
      if (ieee_packet_out !== c_qnan) begin
         errors++;
         $display("FAIL mul got %08h want 7fc00000", ieee_packet_out);
      end
      drive(32'h4120_0000, 32'h4000_0000, op_div);
      checks++;
      if (ieee_packet_out !== c_qnan) begin
         errors++;
         $display("FAIL div got %08h want 7fc00000", ieee_packet_out);
      end
   endtask

   // new operation every cycle, alternating ops
   task automatic test_back_to_back();
      vec_t v [4];
      v = '{
         '{32'h4180_0000, 32'h4200_0000, op_add, 32'h4240_0000},
         '{32'h3F80_0000, 32'h3F80_0000, op_mul, 32'h7FC0_0000},
         '{32'h3F80_0001, 32'h3F80_0000, op_sub, 32'h3400_0000},
         '{32'h3E80_0000, 32'h3F00_0000, op_add, 32'h3F40_0000}
      };
      for (int i = 0; i < 4; i++) begin
         drive(v[i].a, v[i].b, v[i].op);
         checks++;
         if (ieee_packet_out !== v[i].exp) begin
            errors++;
            $display("FAIL b2b[%0d] got %08h want %08h", i, ieee_packet_out, v[i].exp);
         end
      end
   endtask

   task automatic test_mid_reset();
      drive(32'h4180_0000, 32'h4200_0000, op_add);
      checks++;
      if (ieee_packet_out !== 32'h4240_0000) begin
         errors++;
         $display("FAIL pre_reset got %08h want 42400000", ieee_packet_out);
      end
      a_operand = 32'h3F80_0000;
      b_operand = 32'h3F80_0000;
      operation = op_add;
      #2;
      arst_n = 1'b0;
      #1;
      checks++;
      if (ieee_packet_out !== 32'd0) begin
         errors++;
         $display("FAIL async_clear got %08h want 00000000", ieee_packet_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== 32'd0) begin
         errors++;
         $display("FAIL discard_in_flight got %08h want 00000000", ieee_packet_out);
      end
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== 32'h4000_0000) begin
         errors++;
         $display("FAIL post_reset got %08h want 40000000", ieee_packet_out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub();
      test_subnormal();
      test_specials();
      test_unsupported();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
